// File: rtl/hough_peak_finder.sv
// Scans a completed Hough accumulator and keeps the N_PEAKS strongest (rho, theta) cells, vote-sorted.
// Optional non-maximum suppression of nearby peaks is enabled by defining HOUGH_PEAK_NMS_EN.
module hough_peak_finder #(
    parameter int RHO_W      = 10,
    parameter int THETA_W    = 8,
    parameter int RHO_BINS   = 800,
    parameter int THETA_BINS = 180,
    parameter int ACC_W      = 8,
    parameter int N_PEAKS    = 4,
    parameter int THRESHOLD  = 16,
    parameter int NMS_RHO    = 8,
    parameter int NMS_THETA  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic                         done,
    output logic                         busy,
    output logic [THETA_W+RHO_W-1:0]     acc_addr,
    input  logic [ACC_W-1:0]             acc_data,
    output logic [$clog2(N_PEAKS+1)-1:0] peak_count,
    output logic [N_PEAKS*RHO_W-1:0]     peak_rho,
    output logic [N_PEAKS*THETA_W-1:0]   peak_theta,
    output logic [N_PEAKS*ACC_W-1:0]     peak_votes
);
    localparam int AW = THETA_W + RHO_W;
    localparam int CW = $clog2(N_PEAKS + 1);
    localparam int IW = (N_PEAKS > 1) ? $clog2(N_PEAKS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [RHO_W-1:0]   cnt_rho_q;
    logic [THETA_W-1:0] cnt_theta_q;
    logic [AW-1:0]      addr_q;
    logic               vld_q;
    logic               done_q;
    logic               busy_q;
    logic [CW-1:0]      count_q;
    logic [CW-1:0]      count_d;
    logic [ACC_W-1:0]   votes_q [N_PEAKS];
    logic [RHO_W-1:0]   rho_q   [N_PEAKS];
    logic [THETA_W-1:0] theta_q [N_PEAKS];
    logic [ACC_W-1:0]   votes_d [N_PEAKS];
    logic [RHO_W-1:0]   rho_d   [N_PEAKS];
    logic [THETA_W-1:0] theta_d [N_PEAKS];

    logic [ACC_W-1:0]   keep_votes_s [N_PEAKS];
    logic [RHO_W-1:0]   keep_rho_s   [N_PEAKS];
    logic [THETA_W-1:0] keep_theta_s [N_PEAKS];
    logic [CW-1:0]      keep_cnt_s;
    logic [N_PEAKS-1:0] near_s;
    logic               drop_s;
    logic               found_s;
    logic               accept_s;
    int                 pos_s;
    logic [RHO_W-1:0]   tag_rho_s;
    logic [THETA_W-1:0] tag_theta_s;

    // The registered address doubles as the tag for the data beat returned in the same cycle.
    assign tag_rho_s   = addr_q[RHO_W-1:0];
    assign tag_theta_s = addr_q[AW-1:RHO_W];

    function automatic logic near_f(input logic [RHO_W-1:0] ra, input logic [THETA_W-1:0] ta,
                                    input logic [RHO_W-1:0] rb, input logic [THETA_W-1:0] tb);
        int dr;
        int dt;
        dr = (ra >= rb) ? int'(ra - rb) : int'(rb - ra);
        dt = (ta >= tb) ? int'(ta - tb) : int'(tb - ta);
        return (dr <= NMS_RHO) && (dt <= NMS_THETA);
    endfunction

    // Neighbourhood test of the incoming beat against every valid stored peak
    always_comb begin
        near_s = '0;
        drop_s = 1'b0;
`ifdef HOUGH_PEAK_NMS_EN
        for (int i = 0; i < N_PEAKS; i++) begin
            near_s[i] = (i < int'(count_q)) && near_f(rho_q[i], theta_q[i], tag_rho_s, tag_theta_s);
            drop_s    = drop_s || (near_s[i] && (votes_q[i] >= acc_data));
        end
`endif
    end

    // Compact out suppressed slots, then single-cycle sorted insert of the candidate
    always_comb begin
        keep_cnt_s = '0;
        for (int i = 0; i < N_PEAKS; i++) begin
            keep_votes_s[i] = '0;
            keep_rho_s[i]   = '0;
            keep_theta_s[i] = '0;
        end
        for (int i = 0; i < N_PEAKS; i++) begin
            if ((i < int'(count_q)) && !near_s[i]) begin
                keep_votes_s[keep_cnt_s[IW-1:0]] = votes_q[i];
                keep_rho_s[keep_cnt_s[IW-1:0]]   = rho_q[i];
                keep_theta_s[keep_cnt_s[IW-1:0]] = theta_q[i];
                keep_cnt_s = keep_cnt_s + CW'(1);
            end else begin
                keep_cnt_s = keep_cnt_s;
            end
        end

        // Strict greater-than: equal votes never overtake an earlier-scanned entry.
        pos_s   = N_PEAKS;
        found_s = 1'b0;
        for (int i = 0; i < N_PEAKS; i++) begin
            pos_s   = (!found_s && ((i >= int'(keep_cnt_s)) || (acc_data > keep_votes_s[i]))) ? i : pos_s;
            found_s = found_s || (i >= int'(keep_cnt_s)) || (acc_data > keep_votes_s[i]);
        end

        accept_s = vld_q && found_s && !drop_s && (acc_data >= ACC_W'(THRESHOLD)) &&
                   ((count_q < CW'(N_PEAKS)) || (acc_data > votes_q[N_PEAKS-1]));

        count_d = count_q;
        for (int i = 0; i < N_PEAKS; i++) begin
            votes_d[i] = votes_q[i];
            rho_d[i]   = rho_q[i];
            theta_d[i] = theta_q[i];
        end
        if (accept_s) begin
            count_d = (keep_cnt_s < CW'(N_PEAKS)) ? keep_cnt_s + CW'(1) : keep_cnt_s;
            for (int i = 0; i < N_PEAKS; i++) begin
                if (i < pos_s) begin
                    votes_d[i] = keep_votes_s[i];
                    rho_d[i]   = keep_rho_s[i];
                    theta_d[i] = keep_theta_s[i];
                end else if (i == pos_s) begin
                    votes_d[i] = acc_data;
                    rho_d[i]   = tag_rho_s;
                    theta_d[i] = tag_theta_s;
                end else begin
                    votes_d[i] = keep_votes_s[(i > 0) ? i - 1 : 0];
                    rho_d[i]   = keep_rho_s[(i > 0) ? i - 1 : 0];
                    theta_d[i] = keep_theta_s[(i > 0) ? i - 1 : 0];
                end
            end
        end else begin
            count_d = count_q;
        end
    end

    // Scan sequencer, address/tag pipeline and peak list registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_rho_q   <= '0;
            cnt_theta_q <= '0;
            addr_q      <= '0;
            vld_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            count_q     <= '0;
            for (int i = 0; i < N_PEAKS; i++) begin
                votes_q[i] <= '0;
                rho_q[i]   <= '0;
                theta_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    // A start coinciding with the done pulse is deliberately not accepted.
                    if (start && !done_q) begin
                        state_q     <= S_SCAN;
                        cnt_rho_q   <= '0;
                        cnt_theta_q <= '0;
                        addr_q      <= '0;
                        vld_q       <= 1'b0;
                        busy_q      <= 1'b1;
                        count_q     <= '0;
                        for (int i = 0; i < N_PEAKS; i++) begin
                            votes_q[i] <= '0;
                            rho_q[i]   <= '0;
                            theta_q[i] <= '0;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_SCAN: begin
                    addr_q  <= {cnt_theta_q, cnt_rho_q};
                    vld_q   <= 1'b1;
                    count_q <= count_d;
                    for (int i = 0; i < N_PEAKS; i++) begin
                        votes_q[i] <= votes_d[i];
                        rho_q[i]   <= rho_d[i];
                        theta_q[i] <= theta_d[i];
                    end
                    if (cnt_rho_q == RHO_W'(RHO_BINS - 1)) begin
                        cnt_rho_q <= '0;
                        if (cnt_theta_q == THETA_W'(THETA_BINS - 1)) begin
                            state_q <= S_DRAIN;
                        end else begin
                            cnt_theta_q <= cnt_theta_q + THETA_W'(1);
                        end
                    end else begin
                        cnt_rho_q <= cnt_rho_q + RHO_W'(1);
                    end
                end
                S_DRAIN: begin
                    vld_q   <= 1'b0;
                    count_q <= count_d;
                    for (int i = 0; i < N_PEAKS; i++) begin
                        votes_q[i] <= votes_d[i];
                        rho_q[i]   <= rho_d[i];
                        theta_q[i] <= theta_d[i];
                    end
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Flatten the slot registers onto the packed output buses, slot 0 in the LSBs
    always_comb begin
        peak_rho   = '0;
        peak_theta = '0;
        peak_votes = '0;
        for (int i = 0; i < N_PEAKS; i++) begin
            peak_rho[i*RHO_W +: RHO_W]       = rho_q[i];
            peak_theta[i*THETA_W +: THETA_W] = theta_q[i];
            peak_votes[i*ACC_W +: ACC_W]     = votes_q[i];
        end
    end

    assign acc_addr   = addr_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign peak_count = count_q;

endmodule

// File: tb/tb_hough_peak_finder.sv
// Randomized and directed bench for hough_peak_finder on a reduced 64x24 accumulator grid.
module tb_hough_peak_finder;
    localparam int RHO_W   = 10;
    localparam int THETA_W = 8;
    localparam int NP      = 4;
    localparam int TH      = 16;
    localparam int RB      = 64;
    localparam int TB      = 24;
    localparam int T       = RB * TB;
    localparam int AW      = RHO_W + THETA_W;
    localparam int RW      = 3 + NP*RHO_W + NP*THETA_W + NP*8;

    typedef struct {
        int r;
        int t;
        int v;
    } cell_t;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic                   done;
    logic                   busy;
    logic [AW-1:0]          acc_addr;
    logic [7:0]             acc_data;
    logic [2:0]             peak_count;
    logic [NP*RHO_W-1:0]    peak_rho;
    logic [NP*THETA_W-1:0]  peak_theta;
    logic [NP*8-1:0]        peak_votes;
    logic [7:0]             mem [0:(1<<AW)-1];
    int                     checks = 0;
    int                     fails  = 0;

    // The memory answers the address currently presented; the DUT samples it at the next edge.
    assign acc_data = mem[acc_addr];

    hough_peak_finder #(.RHO_BINS(RB), .THETA_BINS(TB)) dut (
        .clk(clk), .reset(reset), .start(start), .done(done), .busy(busy),
        .acc_addr(acc_addr), .acc_data(acc_data), .peak_count(peak_count),
        .peak_rho(peak_rho), .peak_theta(peak_theta), .peak_votes(peak_votes)
    );

    always #5 clk = ~clk;

    task automatic clear_mem();
        for (int a = 0; a < (1 << AW); a++) mem[a] = 8'd0;
    endtask

    task automatic put(input int r, input int t, input int v);
        logic [AW-1:0] a;
        a = {8'(t), 10'(r)};
        mem[a] = 8'(v);
    endtask

`ifdef HOUGH_PEAK_NMS_EN
    function automatic bit bnear(input cell_t a, input int r, input int t);
        int dr;
        int dt;
        dr = (a.r > r) ? a.r - r : r - a.r;
        dt = (a.t > t) ? a.t - t : t - a.t;
        return (dr <= 8) && (dt <= 4);
    endfunction
`endif

    // Reference: stable top-N by votes in scan order (optionally with neighbourhood suppression).
    task automatic model(output logic [RW-1:0] expv);
        cell_t q[$];
        cell_t c;
        logic [NP*RHO_W-1:0]   er;
        logic [NP*THETA_W-1:0] et;
        logic [NP*8-1:0]       ev;
        logic [AW-1:0]         a;
        int p;
        bit drop;
        for (int t = 0; t < TB; t++) begin
            for (int r = 0; r < RB; r++) begin
                a = {8'(t), 10'(r)};
                c.r = r; c.t = t; c.v = int'(mem[a]);
                drop = (c.v < TH);
`ifdef HOUGH_PEAK_NMS_EN
                if (!drop) begin
                    foreach (q[j]) if (bnear(q[j], r, t) && q[j].v >= c.v) drop = 1;
                    if (!drop) for (int j = q.size() - 1; j >= 0; j--) if (bnear(q[j], r, t)) q.delete(j);
                end
`endif
                if (!drop) begin
                    p = q.size();
                    for (int j = q.size() - 1; j >= 0; j--) if (q[j].v < c.v) p = j;
                    q.insert(p, c);
                    if (q.size() > NP) void'(q.pop_back());
                end
            end
        end
        er = '0; et = '0; ev = '0;
        foreach (q[j]) begin
            er[j*RHO_W +: RHO_W]     = 10'(q[j].r);
            et[j*THETA_W +: THETA_W] = 8'(q[j].t);
            ev[j*8 +: 8]             = 8'(q[j].v);
        end
        expv = {3'(q.size()), er, et, ev};
    endtask

    task automatic run_scan(output int lat, output logic b1, output logic [AW-1:0] a1, output logic bafter);
        int n;
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = -1; b1 = 1'b0; a1 = '1; bafter = 1'b1; n = 0;
        while (n < T + 100 && lat < 0) begin
            @(posedge clk); #1; n++;
            if (n == 1) begin b1 = busy; a1 = acc_addr; end
            if (done) lat = n;
        end
        if (lat >= 0) begin
            @(posedge clk); #1 bafter = busy;
        end
    endtask

    function automatic logic [RW-1:0] obs();
        return {peak_count, peak_rho, peak_theta, peak_votes};
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({done, busy, acc_addr, obs()} !== '0) begin
            fails++; $display("FAIL reset_state got %h want 0", {done, busy, acc_addr, obs()});
        end
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_all_zero();
        int lat; logic b1; logic [AW-1:0] a1; logic ba;
        clear_mem();
        run_scan(lat, b1, a1, ba);
        checks++; if (lat !== T + 2) begin fails++; $display("FAIL zero_latency got %0d want %0d", lat, T + 2); end
        checks++; if (b1 !== 1'b1) begin fails++; $display("FAIL busy_edge1 got %b want 1", b1); end
        checks++; if (a1 !== '0) begin fails++; $display("FAIL addr_edge1 got %h want 0", a1); end
        checks++; if (ba !== 1'b0) begin fails++; $display("FAIL busy_fall got %b want 0", ba); end
        checks++; if (obs() !== '0) begin fails++; $display("FAIL zero_result got %h want 0", obs()); end
    endtask

    task automatic test_three_cells();
        int lat; logic b1; logic [AW-1:0] a1; logic ba; logic [RW-1:0] e;
        clear_mem();
        put(10, 5, 40); put(30, 9, 25); put(60, 17, 60); put(2, 2, 15);
        run_scan(lat, b1, a1, ba);
        e = {3'd3, {10'd0, 10'd30, 10'd10, 10'd60}, {8'd0, 8'd9, 8'd5, 8'd17}, {8'd0, 8'd25, 8'd40, 8'd60}};
        checks++; if (lat !== T + 2) begin fails++; $display("FAIL three_latency got %0d want %0d", lat, T + 2); end
        checks++; if (obs() !== e) begin fails++; $display("FAIL three_cells got %h want %h", obs(), e); end
    endtask

    task automatic test_six_cells();
        int lat; logic b1; logic [AW-1:0] a1; logic ba; logic [RW-1:0] e;
        clear_mem();
        put(0, 0, 20); put(5, 3, 30); put(50, 7, 40); put(12, 11, 50); put(33, 16, 60); put(63, 23, 70);
        run_scan(lat, b1, a1, ba);
        e = {3'd4, {10'd50, 10'd12, 10'd33, 10'd63}, {8'd7, 8'd11, 8'd16, 8'd23}, {8'd40, 8'd50, 8'd60, 8'd70}};
        checks++; if (obs() !== e) begin fails++; $display("FAIL six_cells got %h want %h", obs(), e); end
    endtask

    task automatic test_ties();
        int lat; logic b1; logic [AW-1:0] a1; logic ba; logic [RW-1:0] e;
        clear_mem();
        put(5, 1, 30); put(40, 3, 30);
        run_scan(lat, b1, a1, ba);
        e = {3'd2, {10'd0, 10'd0, 10'd40, 10'd5}, {8'd0, 8'd0, 8'd3, 8'd1}, {8'd0, 8'd0, 8'd30, 8'd30}};
        checks++; if (obs() !== e) begin fails++; $display("FAIL tie_order got %h want %h", obs(), e); end
        clear_mem();
        put(1, 1, 50); put(20, 4, 50); put(40, 8, 50); put(60, 12, 50); put(10, 20, 50); put(30, 23, 51);
        run_scan(lat, b1, a1, ba);
        e = {3'd4, {10'd40, 10'd20, 10'd1, 10'd30}, {8'd8, 8'd4, 8'd1, 8'd23}, {8'd50, 8'd50, 8'd50, 8'd51}};
        checks++; if (obs() !== e) begin fails++; $display("FAIL tie_full got %h want %h", obs(), e); end
    endtask

    task automatic test_saturate();
        int lat; logic b1; logic [AW-1:0] a1; logic ba; logic [RW-1:0] e;
        clear_mem();
        put(7, 10, 255); put(30, 15, 255); put(50, 20, 254); put(20, 22, 16); put(45, 0, 15);
        run_scan(lat, b1, a1, ba);
        e = {3'd4, {10'd20, 10'd50, 10'd30, 10'd7}, {8'd22, 8'd20, 8'd15, 8'd10}, {8'd16, 8'd254, 8'd255, 8'd255}};
        checks++; if (obs() !== e) begin fails++; $display("FAIL saturate got %h want %h", obs(), e); end
    endtask

    task automatic test_reset_midscan();
        int lat; logic b1; logic [AW-1:0] a1; logic ba; logic [RW-1:0] e;
        clear_mem();
        put(3, 0, 200);
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (500) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        #1;
        checks++;
        if ({done, busy, acc_addr, obs()} !== '0) begin
            fails++; $display("FAIL midscan_reset got %h want 0", {done, busy, acc_addr, obs()});
        end
        @(negedge clk) reset = 1'b0;
        clear_mem();
        put(15, 6, 90);
        run_scan(lat, b1, a1, ba);
        e = {3'd1, {10'd0, 10'd0, 10'd0, 10'd15}, {8'd0, 8'd0, 8'd0, 8'd6}, {8'd0, 8'd0, 8'd0, 8'd90}};
        checks++; if (lat !== T + 2) begin fails++; $display("FAIL restart_latency got %0d want %0d", lat, T + 2); end
        checks++; if (obs() !== e) begin fails++; $display("FAIL restart_result got %h want %h", obs(), e); end
    endtask

    task automatic test_start_ignored();
        int lat; int n; logic quiet; logic [RW-1:0] e;
        clear_mem();
        put(30, 12, 77); put(1, 0, 33);
        model(e);
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = -1; n = 0;
        while (n < T + 100 && lat < 0) begin
            @(posedge clk); #1; n++;
            start = (n == 99);
            if (done) lat = n;
        end
        start = 1'b1;
        quiet = 1'b1;
        repeat (3) begin
            @(posedge clk); #1 start = 1'b0;
            if (busy || done) quiet = 1'b0;
        end
        checks++; if (lat !== T + 2) begin fails++; $display("FAIL busy_start_latency got %0d want %0d", lat, T + 2); end
        checks++; if (quiet !== 1'b1) begin fails++; $display("FAIL done_cycle_start got %b want 1", quiet); end
        checks++; if (obs() !== e) begin fails++; $display("FAIL start_ignored_result got %h want %h", obs(), e); end
    endtask

    task automatic test_nms_pair();
        int lat; logic b1; logic [AW-1:0] a1; logic ba; logic [RW-1:0] e;
        clear_mem();
        put(20, 10, 50); put(23, 12, 80);
        run_scan(lat, b1, a1, ba);
`ifdef HOUGH_PEAK_NMS_EN
        e = {3'd1, {10'd0, 10'd0, 10'd0, 10'd23}, {8'd0, 8'd0, 8'd0, 8'd12}, {8'd0, 8'd0, 8'd0, 8'd80}};
`else
        e = {3'd2, {10'd0, 10'd0, 10'd20, 10'd23}, {8'd0, 8'd0, 8'd10, 8'd12}, {8'd0, 8'd0, 8'd50, 8'd80}};
`endif
        checks++; if (lat !== T + 2) begin fails++; $display("FAIL nms_latency got %0d want %0d", lat, T + 2); end
        checks++; if (obs() !== e) begin fails++; $display("FAIL nms_pair got %h want %h", obs(), e); end
    endtask

    task automatic test_random();
        int lat; logic b1; logic [AW-1:0] a1; logic ba; logic [RW-1:0] e;
        for (int it = 0; it < 4; it++) begin
            clear_mem();
            for (int k = 0; k < 24; k++) begin
                put(int'($urandom_range(RB - 1, 0)), int'($urandom_range(TB - 1, 0)),
                    (k % 7 == 0) ? 255 : int'($urandom_range(255, 0)));
            end
            model(e);
            run_scan(lat, b1, a1, ba);
            checks++; if (lat !== T + 2) begin fails++; $display("FAIL random_latency it%0d got %0d want %0d", it, lat, T + 2); end
            checks++; if (obs() !== e) begin fails++; $display("FAIL random_result it%0d got %h want %h", it, obs(), e); end
        end
    endtask

    initial begin
        start = 1'b0;
        reset = 1'b1;
        for (int a = 0; a < (1 << AW); a++) mem[a] = 8'd0;
        test_reset();
        test_all_zero();
        test_three_cells();
        test_six_cells();
        test_ties();
        test_saturate();
        test_reset_midscan();
        test_start_ignored();
        test_nms_pair();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/hough_peak_finder.md
# hough_peak_finder

Scans the completed Hough accumulator memory written by `hough_transform_coordinate` and extracts the N strongest (rho, theta) cells as line candidates for the Rectilinearizer corner solver. It sits directly downstream of the accumulator stage:
- It is started by that stage's `done` pulse.
- It reads the accumulator BRAM through a synchronous read port.
- It presents a vote-sorted peak list with its own `start`/`done` handshake.

## Interface
Parameters:
- `RHO_W`, 10: rho index width.
- `THETA_W`, 8: theta index width.
- `RHO_BINS`, 800: rho bins scanned, at most 2^RHO_W.
- `THETA_BINS`, 180: theta bins scanned, at most 2^THETA_W.
- `ACC_W`, 8: vote count width.
- `N_PEAKS`, 4: peak list depth.
- `THRESHOLD`, 16: minimum votes for a cell to be a peak.
- `NMS_RHO`, 8: suppression window half-width in rho (used only with the macro).
- `NMS_THETA`, 4: suppression window half-width in theta (used only with the macro).

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a scan; ignored unless IDLE.
- `done` out 1: one-cycle pulse when the peak list is final.
- `busy` out 1: high from the cycle after `start` through the `done` cycle.
- `acc_addr` out THETA_W+RHO_W: accumulator read address {theta, rho}.
- `acc_data` in ACC_W: read data, valid exactly one cycle after `acc_addr`.
- `peak_count` out clog2(N_PEAKS+1): number of valid entries.
- `peak_rho` out N_PEAKS*RHO_W: packed rho values; slot 0 in the LSBs.
- `peak_theta` out N_PEAKS*THETA_W: packed theta values.
- `peak_votes` out N_PEAKS*ACC_W: packed vote counts; slot 0 holds the strongest.

## Operation
- State machine: IDLE -> SCAN -> DRAIN -> DONE -> IDLE.
- IDLE -> SCAN on `start`:
  - Clear all slots and `peak_count`.
  - Zero the theta and rho counters.
- SCAN:
  - Issue one address per cycle.
  - rho increments from 0 to RHO_BINS-1, then wraps to 0 and theta increments.
  - After issuing {THETA_BINS-1, RHO_BINS-1}, go to DRAIN.
- Pipeline: the registered address is tagged with a valid bit. `acc_data` pairs with the previous cycle's tag.
- Candidate rule: votes >= THRESHOLD, and either `peak_count` < N_PEAKS or votes strictly greater than slot N_PEAKS-1.
- Insertion: a single-cycle sorted insert.
  - Slots below the insertion point are unchanged.
  - Slots at and after it shift down one place, and the last slot is discarded.
  - Order is descending by votes.
  - Ties: the earlier-scanned cell keeps the higher slot. A strict greater-than is required to displace an entry.
- DRAIN: one cycle that evaluates the final data beat, then go to DONE.
- DONE: assert `done` for one cycle, then go to IDLE.
- Outputs hold their values until the next accepted `start`.
- Invalid slots (index >= `peak_count`) read as zero.
- Vote counts are unsigned. Saturated accumulator values (all ones) compare normally.
- `start` while busy: ignored, with no restart.
- `start` in the same cycle as `done`: ignored.
- `reset` at any time, including mid-scan:
  - Go to IDLE immediately.
  - All slots, `peak_count`, `acc_addr`, `done` and `busy` become 0.
  - No partial result is retained.

## Timing
- Reset values: `done`=0, `busy`=0, `acc_addr`=0, `peak_count`=0, and all peak buses 0.
- Let T = RHO_BINS*THETA_BINS. `start` is sampled high at edge 0.
- Edge 1: `acc_addr`=0 and `busy`=1.
- Address k is presented after edge k+1; its data is evaluated at edge k+2.
- The last data beat is evaluated in DRAIN at edge T+1.
- `done`=1 during the cycle after edge T+2.
- `busy` falls at edge T+3.
- Total latency from `start` to `done` is T+2 cycles. Defaults give 144002.
- The peak list is stable and valid in the `done` cycle and afterwards.
- Throughput is one accumulator cell per cycle, with no stalls.

## Configuration
- `HOUGH_PEAK_NMS_EN`, defined: non-maximum suppression.
  - A qualifying candidate is compared with every valid stored peak where |drho| <= NMS_RHO and |dtheta| <= NMS_THETA.
  - If any such peak has votes >= the candidate, the candidate is dropped.
  - Otherwise all such weaker peaks are removed and the list is compacted. The candidate is then inserted in the same cycle.
  - Theta distance does not wrap at THETA_BINS.
  - Latency is unchanged.
- Undefined: no suppression; the pure top-N rule applies. The NMS parameters are unused.

## Test plan
- All-zero accumulator, start -> `done` exactly T+2 cycles later; `peak_count`=0; all buses 0.
- Cells (10,5)=40, (300,90)=25, (700,170)=60, (2,2)=15 (below threshold) -> count=3; slots (700,170,60), (10,5,40), (300,90,25).
- Six cells with votes 20,30,40,50,60,70 in scan order -> count=4; votes 70,60,50,40.
- Two cells both at 30 -> the earlier-scanned cell is in slot 0.
- Reset asserted at cycle 500 of a scan, then a new start -> `done` at the full T+2 latency; no stale peaks.
- With NMS: (100,40)=50 then (103,42)=80 -> a single peak, (103,42,80). Without NMS -> two peaks, 80 then 50.
